// File: rtl/bubble_sort_seq_ctrl_if.sv
// Stream bundle for the sequential sorter: producer side (in_*) and consumer side (out_*).
// The sorter connects through the slave modport; the environment driving it uses master.
// Each stream is a plain valid/ready handshake; a beat transfers when valid and ready are both high.
interface bubble_sort_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/bubble_sort_seq_ctrl.sv
// Sequential ascending sorter: serial load, in-place bubble passes with one shared comparator, serial unload.
// Latency: DIM load beats, then P*(DIM-1) sort cycles (P in 1..DIM-1, early exit), then DIM unload beats.
// Backpressure: in_ready is high only while loading; out_data is held stable while out_valid && !out_ready.
module bubble_sort_seq_ctrl #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DIM*(DIM-1)/2+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  bubble_sort_seq_ctrl_if.slave bus,
  output logic                 busy,
  output logic [CW-1:0]        swap_cnt
);

  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIM-1);
  localparam logic [IW-1:0] LAST_PAIR = IW'(DIM-2);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SORT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [DIM];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    j;
  logic [IW-1:0]    pass;
  logic             swapped_flag;

  // Shared comparator on the current adjacent pair.
  logic [WIDTH-1:0] elem_lo, elem_hi;
  logic             do_swap, flag_now, end_pass, sort_done;
  logic             in_fire, out_fire;

  assign elem_lo   = mem[j];
  assign elem_hi   = mem[j + IW'(1)];
  assign do_swap   = (elem_lo > elem_hi);
  assign flag_now  = swapped_flag | do_swap;
  assign end_pass  = (j == LAST_PAIR);
  assign sort_done = end_pass && (!flag_now || (pass == LAST_PAIR));

  assign in_fire   = (state == S_LOAD) && bus.in_valid;
  assign out_fire  = (state == S_OUT) && bus.out_ready;

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_data  = (state == S_OUT) ? mem[rd_idx] : '0;
  assign bus.out_last  = (state == S_OUT) && (rd_idx == LAST_IDX);
  assign busy          = (state == S_SORT) || (state == S_OUT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // Phase sequencing: load -> sort -> unload -> load.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (in_fire && (wr_idx == LAST_IDX)) state_nxt = S_SORT;
      S_SORT:  if (sort_done) state_nxt = S_OUT;
      S_OUT:   if (out_fire && (rd_idx == LAST_IDX)) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Indices, pass bookkeeping and swap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      j            <= '0;
      pass         <= '0;
      swapped_flag <= 1'b0;
      swap_cnt     <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_fire) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx       <= '0;
              j            <= '0;
              pass         <= '0;
              swapped_flag <= 1'b0;
              swap_cnt     <= '0;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        S_SORT: begin
          if (do_swap) swap_cnt <= swap_cnt + CW'(1);
          if (!end_pass) begin
            j            <= j + IW'(1);
            swapped_flag <= flag_now;
          end else if (!sort_done) begin
            pass         <= pass + IW'(1);
            j            <= '0;
            swapped_flag <= 1'b0;
          end
        end
        S_OUT: begin
          if (out_fire) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= '0;
              wr_idx <= '0;
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Element storage: serial writes during load, in-place compare-swap during sort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_fire) begin
        mem[wr_idx] <= bus.in_data;
      end else if ((state == S_SORT) && do_swap) begin
        mem[j]            <= elem_hi;
        mem[j + IW'(1)]   <= elem_lo;
      end
    end
  end

endmodule
